// File: rtl/t_pass_collector_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : t_pass_collector_pkg                                  |
// | Brief    : Shared types, widths and helpers for t_pass_collector |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
package t_pass_collector_pkg;

  // Supervisor states; the encoding is fixed so it reads well on a wave viewer
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  // Width of the externally reported cycle count
  localparam int CYCLES_W = 32;

  // Bits needed for a counter holding values 0..n-1 (never less than one bit)
  function automatic int count_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/t_pass_collector_strobe_div.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : t_strobe_div                                          |
// | Brief    : Registered clock-enable divider; one-cycle stb every  |
// |            DIV enabled cycles, first pulse DIV-1 cycles after clr |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module t_strobe_div
  import t_pass_collector_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic fastclk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic stb
);

  localparam int             c_W    = count_width(DIV);
  localparam logic [c_W-1:0] c_LAST = c_W'(DIV - 1);

  logic [c_W-1:0] r_cnt;
  logic [c_W-1:0] w_cnt_nxt;
  logic           r_stb;

  // Next divider phase, wrapping at DIV-1
  always_comb begin
    w_cnt_nxt = (r_cnt == c_LAST) ? '0 : r_cnt + c_W'(1);
  end

  // clr loads phase 0 (the strobe is already due if DIV is 1); stb is registered
  // alongside the phase it belongs to so it carries no combinational path
  always_ff @(posedge fastclk) begin
    if (reset) begin
      r_cnt <= '0;
      r_stb <= 1'b0;
    end else if (clr) begin
      r_cnt <= '0;
      r_stb <= (c_LAST == '0);
    end else if (en) begin
      r_cnt <= w_cnt_nxt;
      r_stb <= (w_cnt_nxt == c_LAST);
    end else begin
      r_cnt <= '0;
      r_stb <= 1'b0;
    end
  end

  assign stb = r_stb;

endmodule
`default_nettype wire

// File: rtl/t_pass_collector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : t_pass_collector                                      |
// | Brief    : Supervises NTESTS sticky pass flags, generates the    |
// |            check strobe, reports DONE or timeout FAIL verdict    |
// | Macro    : T_PASS_COLLECTOR_STOP_EN (simulation verdict print)   |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module t_pass_collector
  import t_pass_collector_pkg::*;
#(
  parameter int NTESTS  = 4,
  parameter int TIMEOUT = 1000,
  parameter int DIV     = 2
) (
  input  logic                fastclk,
  input  logic                reset,
  input  logic                start,
  input  logic [NTESTS-1:0]   passed_i,
  output logic                check_stb,
  output logic                running,
  output logic                done,
  output logic                all_passed,
  output logic [NTESTS-1:0]   fail_mask,
  output logic [CYCLES_W-1:0] cycles
);

  localparam int            c_CW   = count_width(TIMEOUT + 1);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [NTESTS-1:0] r_seen;
  logic [NTESTS-1:0] w_seen_all;
  logic [NTESTS-1:0] r_fail_mask;
  logic [c_CW-1:0]   r_cnt;
  logic              w_enter_run;
  logic              w_stay_run;

  assign w_seen_all  = r_seen | passed_i;
  assign w_enter_run = (r_state != ST_RUN) && (w_state_nxt == ST_RUN);
  assign w_stay_run  = (r_state == ST_RUN) && (w_state_nxt == ST_RUN);

  // Next-state: completion has priority over timeout; start only matters outside RUN
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (&w_seen_all)         w_state_nxt = ST_DONE;
        else if (r_cnt == c_LAST) w_state_nxt = ST_FAIL;
      end
      ST_DONE: if (start) w_state_nxt = ST_RUN;
      ST_FAIL: if (start) w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset aborts any run without leaving a verdict
  always_ff @(posedge fastclk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Run bookkeeping: sticky flags, elapsed count (tops out at TIMEOUT), failure mask
  always_ff @(posedge fastclk) begin
    if (reset) begin
      r_seen      <= '0;
      r_cnt       <= '0;
      r_fail_mask <= '0;
    end else if (w_enter_run) begin
      r_seen      <= '0;
      r_cnt       <= '0;
      r_fail_mask <= '0;
    end else if (r_state == ST_RUN) begin
      r_seen <= w_seen_all;
      r_cnt  <= r_cnt + c_CW'(1);
      if (w_state_nxt == ST_FAIL) r_fail_mask <= ~w_seen_all;
    end
  end

  t_strobe_div #(
    .DIV(DIV)
  ) u_strobe_div (
    .fastclk(fastclk),
    .reset  (reset),
    .clr    (w_enter_run),
    .en     (w_stay_run),
    .stb    (check_stb)
  );

  assign running    = (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE) || (r_state == ST_FAIL);
  assign all_passed = (r_state == ST_DONE);
  assign fail_mask  = r_fail_mask;
  assign cycles     = CYCLES_W'(r_cnt);

`ifdef T_PASS_COLLECTOR_STOP_EN
  // Announce the verdict on the edge that enters DONE or FAIL
  always_ff @(posedge fastclk) begin
    if (!reset && r_state == ST_RUN && w_state_nxt == ST_DONE) begin
      $display("[%0t] t_pass_collector: Passed", $time);
    end
    if (!reset && r_state == ST_RUN && w_state_nxt == ST_FAIL) begin
      $display("[%0t] t_pass_collector: FAIL mask=%h", $time, ~w_seen_all);
      $stop;
    end
  end
`else
  // Verdict is reported on the ports only
`endif

endmodule
`default_nettype wire

// File: tb/tb_t_pass_collector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_t_pass_collector                                   |
// | Brief    : Self-checking bench: directed scenarios plus random   |
// |            traffic against a behavioural model; DIV=3 and DIV=1  |
// | Revision : 1.0  initial release                                  |
// +------------------------------------------------------------------+
module tb_t_pass_collector;

  localparam int NT  = 4;
  localparam int TMO = 20;

  localparam int P_IDLE = 0;
  localparam int P_RUN  = 1;
  localparam int P_DONE = 2;
  localparam int P_TMO  = 3;

  logic          fastclk = 1'b0;
  logic          reset   = 1'b1;
  logic          start   = 1'b0;
  logic [NT-1:0] passed_i = '0;

  logic          a_stb, a_running, a_done, a_all_passed;
  logic [NT-1:0] a_fail_mask;
  logic [31:0]   a_cycles;
  logic          b_stb, b_running, b_done, b_all_passed;
  logic [NT-1:0] b_fail_mask;
  logic [31:0]   b_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int            m_phase = P_IDLE;
  int            m_k     = 0;
  logic [NT-1:0] m_seen  = '0;
  logic [NT-1:0] m_mask  = '0;
  bit            m_valid = 1'b0;

  always #5 fastclk = ~fastclk;

  t_pass_collector #(.NTESTS(NT), .TIMEOUT(TMO), .DIV(3)) u_dut_d3 (
    .fastclk(fastclk), .reset(reset), .start(start), .passed_i(passed_i),
    .check_stb(a_stb), .running(a_running), .done(a_done),
    .all_passed(a_all_passed), .fail_mask(a_fail_mask), .cycles(a_cycles)
  );

  t_pass_collector #(.NTESTS(NT), .TIMEOUT(TMO), .DIV(1)) u_dut_d1 (
    .fastclk(fastclk), .reset(reset), .start(start), .passed_i(passed_i),
    .check_stb(b_stb), .running(b_running), .done(b_done),
    .all_passed(b_all_passed), .fail_mask(b_fail_mask), .cycles(b_cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one edge of the supervisor expressed as the verdict rules
  always @(posedge fastclk) begin
    if (reset) begin
      m_phase = P_IDLE; m_k = 0; m_seen = '0; m_mask = '0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_phase == P_RUN) begin
        m_seen = m_seen | passed_i;
        m_k    = m_k + 1;
        if (m_seen == {NT{1'b1}}) m_phase = P_DONE;
        else if (m_k == TMO) begin
          m_phase = P_TMO;
          m_mask  = ~m_seen;
        end
      end else if (start) begin
        m_phase = P_RUN; m_k = 0; m_seen = '0; m_mask = '0;
      end
    end
  end

  // Compare both DUTs against the model every cycle, away from the active edge
  always @(negedge fastclk) begin
    if (m_valid) begin
      logic          e_run;
      logic [NT-1:0] e_mask;
      e_run  = (m_phase == P_RUN);
      e_mask = (m_phase == P_TMO) ? m_mask : '0;
      chk("running_d3",    {31'd0, a_running},    {31'd0, e_run});
      chk("done_d3",       {31'd0, a_done},       {31'd0, m_phase >= P_DONE});
      chk("all_passed_d3", {31'd0, a_all_passed}, {31'd0, m_phase == P_DONE});
      chk("fail_mask_d3",  {28'd0, a_fail_mask},  {28'd0, e_mask});
      chk("cycles_d3",     a_cycles,              32'(m_k));
      chk("stb_d3",        {31'd0, a_stb},        {31'd0, e_run && (m_k % 3 == 2)});
      chk("running_d1",    {31'd0, b_running},    {31'd0, e_run});
      chk("done_d1",       {31'd0, b_done},       {31'd0, m_phase >= P_DONE});
      chk("fail_mask_d1",  {28'd0, b_fail_mask},  {28'd0, e_mask});
      chk("cycles_d1",     b_cycles,              32'(m_k));
      chk("stb_d1",        {31'd0, b_stb},        {31'd0, e_run});
    end
  end

  // One cycle of stimulus, applied just after a falling edge
  task automatic drive(input logic s, input logic [NT-1:0] p, input logic r);
    start    = s;
    passed_i = p;
    reset    = r;
    @(negedge fastclk);
  endtask

  initial begin
    logic [NT-1:0] p;

    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    chk("rst_running", {31'd0, a_running}, 32'd0);
    chk("rst_done",    {31'd0, a_done},    32'd0);
    chk("rst_stb",     {31'd0, a_stb},     32'd0);
    chk("rst_cycles",  a_cycles,           32'd0);
    drive(1'b0, '0, 1'b0);

    // All flags arrive together at RUN cycle 3
    drive(1'b1, '0, 1'b0);
    chk("lit_start_running", {31'd0, a_running}, 32'd1);
    for (int i = 0; i < 4; i++) drive(1'b0, (i >= 3) ? 4'hF : 4'h0, 1'b0);
    chk("lit1_done",   {31'd0, a_done},       32'd1);
    chk("lit1_all",    {31'd0, a_all_passed}, 32'd1);
    chk("lit1_cycles", a_cycles,              32'd4);
    chk("lit1_mask",   {28'd0, a_fail_mask},  32'd0);
    drive(1'b0, '0, 1'b0);

    // Staggered one-cycle pulses; sticky flags must complete the set
    drive(1'b1, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("lit2_stb_d3", {31'd0, a_stb}, {31'd0, (i % 3) == 2});
      case (i)
        2:       p = 4'b0001;
        5:       p = 4'b0010;
        7:       p = 4'b0100;
        9:       p = 4'b1000;
        default: p = 4'b0000;
      endcase
      drive(1'b0, p, 1'b0);
    end
    chk("lit2_all",    {31'd0, a_all_passed}, 32'd1);
    chk("lit2_cycles", a_cycles,              32'd10);
    chk("lit2_stb_off", {31'd0, a_stb},       32'd0);

    // Timeout with half the flags present
    drive(1'b1, '0, 1'b0);
    for (int i = 0; i < TMO; i++) begin
      if (i == TMO - 1) chk("lit3_not_yet", {31'd0, a_done}, 32'd0);
      drive(1'b0, 4'b0101, 1'b0);
    end
    chk("lit3_done",   {31'd0, a_done},       32'd1);
    chk("lit3_all",    {31'd0, a_all_passed}, 32'd0);
    chk("lit3_mask",   {28'd0, a_fail_mask},  32'hA);
    chk("lit3_cycles", a_cycles,              32'd20);

    // Restart from the timeout verdict; last flag lands on the final count
    drive(1'b1, '0, 1'b0);
    chk("lit4_mask_clr",   {28'd0, a_fail_mask}, 32'd0);
    chk("lit4_cycles_clr", a_cycles,             32'd0);
    for (int i = 0; i < TMO; i++) drive(1'b0, (i == TMO - 1) ? 4'hF : 4'h7, 1'b0);
    chk("lit4_all",    {31'd0, a_all_passed}, 32'd1);
    chk("lit4_cycles", a_cycles,              32'd20);

    // Reset mid-run, and reset beating start
    drive(1'b1, '0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b0);
    chk("lit5_cycles_pre", a_cycles, 32'd6);
    drive(1'b0, '0, 1'b1);
    chk("lit5_running", {31'd0, a_running}, 32'd0);
    chk("lit5_done",    {31'd0, a_done},    32'd0);
    chk("lit5_cycles",  a_cycles,           32'd0);
    drive(1'b1, '0, 1'b1);
    chk("lit5_rst_wins", {31'd0, a_running}, 32'd0);
    drive(1'b0, '0, 1'b0);

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < NT; b++) p[b] = ($urandom_range(0, 7) == 0);
      drive(($urandom_range(0, 9) == 0), p, ($urandom_range(0, 149) == 0));
    end
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
